// File: rtl/traffic_tick_gen.sv
// rtl/traffic_tick_gen.sv - programmable tick timebase with pause, single-step and shadowed period reload
// Optional TRAFFIC_TICK_GEN_COUNT_EN adds a saturating tick_total counter output.
module traffic_tick_gen #(
   parameter int PERIOD_W       = 16,
   parameter int DEFAULT_PERIOD = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                period_wr,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                step,
   output logic                tick,
   output logic [PERIOD_W-1:0] period_cur,
   output logic                pending
`ifdef TRAFFIC_TICK_GEN_COUNT_EN
   ,
   output logic [31:0]         tick_total
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

   localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_W-1:0] DEF = DEFAULT_PERIOD[PERIOD_W-1:0];

   state_t              state;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] shadow;
   logic [PERIOD_W-1:0] wr_val;
   logic                wrap;

   assign wr_val = (period_in == '0) ? ONE : period_in;
   assign wrap   = (cnt == period_cur - ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shadow     <= '0;
         period_cur <= DEF;
         pending    <= 1'b0;
         tick       <= 1'b0;
      end else if (en) begin
         state <= RUN;
         if (wrap) begin
            // A write landing on the wrap edge governs the next interval directly.
            cnt     <= '0;
            tick    <= 1'b1;
            pending <= 1'b0;
            if (period_wr)
               period_cur <= wr_val;
            else if (pending)
               period_cur <= shadow;
         end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
            if (period_wr) begin
               shadow  <= wr_val;
               pending <= 1'b1;
            end
         end
      end else begin
         // Paused: period changes take effect at once and restart the interval.
         if (period_wr) begin
            period_cur <= wr_val;
            cnt        <= '0;
            pending    <= 1'b0;
         end
         if (state == IDLE && step) begin
            state <= STEP;
            tick  <= 1'b1;
         end else begin
            state <= IDLE;
            tick  <= 1'b0;
         end
      end
   end

`ifdef TRAFFIC_TICK_GEN_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         tick_total <= '0;
      else if (tick && tick_total != 32'hFFFF_FFFF)
         tick_total <= tick_total + 32'd1;
   end
`else
   // No tick counter in this build.
`endif

endmodule

// File: tb/tb_traffic_tick_gen.sv
// tb/tb_traffic_tick_gen.sv - directed and randomized checks of traffic_tick_gen against a reference model
module tb_traffic_tick_gen;

   localparam int W  = 16;
   localparam int DP = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         period_wr = 1'b0;
   logic [W-1:0] period_in = '0;
   logic         step = 1'b0;
   logic         tick;
   logic [W-1:0] period_cur;
   logic         pending;
`ifdef TRAFFIC_TICK_GEN_COUNT_EN
   logic [31:0]  tick_total;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   traffic_tick_gen #(.PERIOD_W(W), .DEFAULT_PERIOD(DP)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .period_wr  (period_wr),
      .period_in  (period_in),
      .step       (step),
      .tick       (tick),
      .period_cur (period_cur),
      .pending    (pending)
`ifdef TRAFFIC_TICK_GEN_COUNT_EN
      ,
      .tick_total (tick_total)
`endif
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position within the interval, period in effect, and the
   // queued period (if any); a step tick is allowed only after an idle edge.
   bit     model_on = 0;
   int     m_elapsed, m_per, m_queued, wv;
   bit     m_pend, m_tick, m_prev_idle;
   longint m_total;

   always @(posedge clk) begin
      wv = (period_in == 0) ? 1 : int'(period_in);
      if (rst) begin
         model_on = 1; m_elapsed = 0; m_per = DP; m_pend = 0; m_tick = 0;
         m_prev_idle = 1; m_total = 0; m_queued = 0;
      end else begin
         if (m_tick && m_total < 64'hFFFF_FFFF) m_total++;
         if (en) begin
            m_elapsed++;
            m_tick = (m_elapsed == m_per);
            if (m_tick) begin
               m_elapsed = 0;
               if (period_wr) m_per = wv;
               else if (m_pend) m_per = m_queued;
               m_pend = 0;
            end else if (period_wr) begin
               m_queued = wv; m_pend = 1;
            end
            m_prev_idle = 0;
         end else begin
            m_tick = step && m_prev_idle;
            m_prev_idle = !m_tick;
            if (period_wr) begin
               m_per = wv; m_elapsed = 0; m_pend = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("cmp_tick", tick, m_tick);
         chk("cmp_period_cur", period_cur, m_per);
         chk("cmp_pending", pending, m_pend);
`ifdef TRAFFIC_TICK_GEN_COUNT_EN
         chk("cmp_tick_total", tick_total, m_total);
`endif
      end
   end

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; en = 0; period_wr = 0; step = 0; period_in = '0;
      edge_();
      rst = 0;
      chk("rst_tick", tick, 0);
      chk("rst_period_cur", period_cur, DP);
      chk("rst_pending", pending, 0);
   endtask

   initial begin
      // Free run at the default period: ticks after edges 6, 12, ... 36.
      do_reset();
      en = 1;
      for (int k = 1; k <= 40; k++) begin
         edge_();
         chk("s1_tick", tick, (k % 6) == 0);
      end
      chk("s1_period_cur", period_cur, 6);
`ifdef TRAFFIC_TICK_GEN_COUNT_EN
      chk("s6_total", tick_total, 6);
      rst = 1; edge_(); rst = 0;
      chk("s6_total_rst", tick_total, 0);
`endif

      // Shadowed reload: write 3 at cnt=2, current interval still ends at 6.
      do_reset();
      en = 1;
      edge_(); edge_();
      period_in = 3; period_wr = 1;
      edge_();
      period_wr = 0;
      chk("s2_pending_set", pending, 1);
      chk("s2_period_hold", period_cur, 6);
      for (int k = 4; k <= 15; k++) begin
         edge_();
         chk("s2_tick", tick, (k == 6 || k == 9 || k == 12 || k == 15));
         chk("s2_pending", pending, k < 6);
      end
      chk("s2_period_new", period_cur, 3);

      // Pause at cnt=4, resume: next tick two edges later.
      do_reset();
      en = 1;
      for (int k = 0; k < 4; k++) edge_();
      en = 0;
      for (int k = 0; k < 10; k++) begin
         edge_();
         chk("s3_pause_tick", tick, 0);
      end
      en = 1;
      edge_();
      chk("s3_resume1", tick, 0);
      edge_();
      chk("s3_resume2", tick, 1);

      // Idle write of 0 clamps to 1; three back-to-back steps give 1,0,1.
      do_reset();
      period_in = '0; period_wr = 1;
      edge_();
      period_wr = 0;
      chk("s4_period_cur", period_cur, 1);
      chk("s4_pending", pending, 0);
      step = 1;
      edge_(); chk("s4_step1", tick, 1);
      edge_(); chk("s4_step2", tick, 0);
      edge_(); chk("s4_step3", tick, 1);
      step = 0; en = 1;
      for (int k = 0; k < 5; k++) begin
         edge_();
         chk("s4_run_tick", tick, 1);
      end

      // Reset mid-interval with a pending write.
      do_reset();
      en = 1;
      edge_(); edge_();
      period_in = 5; period_wr = 1;
      edge_();
      period_wr = 0;
      chk("s5_pending_pre", pending, 1);
      rst = 1;
      edge_();
      rst = 0;
      chk("s5_tick", tick, 0);
      chk("s5_period_cur", period_cur, 6);
      chk("s5_pending", pending, 0);
      for (int k = 1; k <= 12; k++) begin
         edge_();
         chk("s5_restart_tick", tick, (k % 6) == 0);
      end

      // Randomized run checked by the model compare process.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 11) == 0) en = ~en;
         period_wr = ($urandom_range(0, 9) == 0);
         period_in = W'($urandom_range(0, 9));
         step      = ($urandom_range(0, 2) == 0);
         edge_();
      end
      rst = 0; en = 0; period_wr = 0; step = 0;
      edge_();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
